// File: rtl/fb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_pkg: shared state type and default burst/starvation limits for the
//         frame-buffer arbiter and the display fetch block.   Rev 1.0
// ----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CMD  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_CMD  = 2'd3
    } fb_state_t;

    localparam int FB_BURST  = 16;
    localparam int FB_STARVE = 4;

endpackage
`default_nettype wire

// File: rtl/fb_starve_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_starve_cnt: saturating count of read grants taken while the writer waits.
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_starve_cnt
    import fb_pkg::*;
#(
    parameter int STARVE = FB_STARVE
) (
    input  logic pixel_clk,
    input  logic pixel_rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(STARVE + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat = (cnt_q == CW'(STARVE));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_arbiter: arbitrates display burst reads and single-word writes onto one
//             memory port, with bounded writer starvation.   Rev 1.0
// ----------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BURST  = FB_BURST,
    parameter int STARVE = FB_STARVE
) (
    input  logic                    pixel_clk,
    input  logic                    pixel_rst_n,
    input  logic                    rd_req,
    input  logic [AW-1:0]           rd_addr,
    output logic                    rd_gnt,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_valid,
    output logic                    rd_done,
    input  logic                    wr_req,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    output logic                    wr_ack,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [AW-1:0]           mem_address,
    output logic [$clog2(BURST):0]  mem_burstcount,
    output logic [DW-1:0]           mem_writedata,
    input  logic                    mem_waitrequest,
    input  logic [DW-1:0]           mem_readdata,
    input  logic                    mem_readdatavalid
);

    localparam int BW = $clog2(BURST) + 1;

    fb_state_t      state_q;
    logic [BW-1:0]  beat_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [BW-1:0]  bcnt_q;

    logic           starve_sat;
    logic           sel_rd;
    logic           sel_wr;
    logic           rd_accept;
    logic           wr_accept;
    logic           last_beat;

    // Read wins a tie until the writer has been passed over STARVE times.
    assign sel_rd    = rd_req && !(wr_req && starve_sat);
    assign sel_wr    = wr_req && !sel_rd;
    assign rd_accept = (state_q == ST_RD_CMD) && !mem_waitrequest;
    assign wr_accept = (state_q == ST_WR_CMD) && !mem_waitrequest;
    assign last_beat = (beat_q == BW'(BURST - 1));

    // Beats are only forwarded while a burst is outstanding.
    assign rd_valid  = (state_q == ST_RD_DATA) && mem_readdatavalid;
    assign rd_data   = rd_valid ? mem_readdata : '0;
    assign rd_done   = rd_valid && last_beat;
    assign rd_gnt    = rd_accept;
    assign wr_ack    = wr_accept;

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_burstcount = bcnt_q;
    assign mem_writedata  = wdata_q;

    fb_starve_cnt #(
        .STARVE      (STARVE)
    ) u_starve (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .inc         (rd_accept && wr_req),
        .clr         (wr_accept || (rd_accept && !wr_req)),
        .sat         (starve_sat)
    );

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bcnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_rd) begin
                        state_q    <= ST_RD_CMD;
                        mem_read_q <= 1'b1;
                        addr_q     <= rd_addr;
                        bcnt_q     <= BW'(BURST);
                    end else if (sel_wr) begin
                        state_q     <= ST_WR_CMD;
                        mem_write_q <= 1'b1;
                        addr_q      <= wr_addr;
                        wdata_q     <= wr_data;
                        bcnt_q      <= BW'(1);
                    end
                end
                ST_RD_CMD: begin
                    if (!mem_waitrequest) begin
                        state_q    <= ST_RD_DATA;
                        mem_read_q <= 1'b0;
                        beat_q     <= '0;
                    end
                end
                ST_RD_DATA: begin
                    if (mem_readdatavalid) begin
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q  <= beat_q + BW'(1);
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (!mem_waitrequest) begin
                        state_q     <= ST_IDLE;
                        mem_write_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fb_arbiter: randomized scenario bench for fb_arbiter.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_fb_arbiter;
    import fb_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BURST  = FB_BURST;
    localparam int STARVE = FB_STARVE;
    localparam int BCW    = $clog2(BURST) + 1;
    localparam int OW     = 5 + 1 + 1 + DW + AW + BCW + DW;

    logic           pixel_clk = 1'b0;
    logic           pixel_rst_n = 1'b0;
    logic           rd_req, wr_req, mem_waitrequest, mem_readdatavalid;
    logic [AW-1:0]  rd_addr, wr_addr;
    logic [DW-1:0]  wr_data, mem_readdata;
    logic           rd_gnt, rd_valid, rd_done, wr_ack, mem_read, mem_write;
    logic [DW-1:0]  rd_data, mem_writedata;
    logic [AW-1:0]  mem_address;
    logic [BCW-1:0] mem_burstcount;
    logic [OW-1:0]  all_outs;

    int checks   = 0;
    int failures = 0;

    assign all_outs = {rd_gnt, rd_valid, rd_done, wr_ack, mem_read, mem_write,
                       rd_data, mem_address, mem_burstcount, mem_writedata};

    always #5 pixel_clk = ~pixel_clk;

    fb_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .STARVE(STARVE)) dut (
        .pixel_clk         (pixel_clk),
        .pixel_rst_n       (pixel_rst_n),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_gnt            (rd_gnt),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_done           (rd_done),
        .wr_req            (wr_req),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_ack            (wr_ack),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_burstcount    (mem_burstcount),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    // Protocol watch: exclusive commands, and command held across a stall.
    logic           mon_stall = 1'b0;
    logic [1+1+AW+BCW+DW-1:0] mon_cmd;
    always @(negedge pixel_clk) begin
        if (pixel_rst_n) begin
            checks++;
            if (mem_read && mem_write) begin
                failures++;
                $display("FAIL cmd_exclusive: read=%0b write=%0b required not both 1", mem_read, mem_write);
            end
            if (mon_stall) begin
                checks++;
                if ({mem_read, mem_write, mem_address, mem_burstcount, mem_writedata} !== mon_cmd) begin
                    failures++;
                    $display("FAIL cmd_stable: got=%h required=%h",
                             {mem_read, mem_write, mem_address, mem_burstcount, mem_writedata}, mon_cmd);
                end
            end
            mon_stall = (mem_read || mem_write) && mem_waitrequest;
            mon_cmd   = {mem_read, mem_write, mem_address, mem_burstcount, mem_writedata};
        end else begin
            mon_stall = 1'b0;
        end
    end

    task automatic idle_inputs();
        rd_req = 1'b0; wr_req = 1'b0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; mem_readdata = '0;
    endtask

    task automatic cyc_begin();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic cyc_sample();
        @(negedge pixel_clk);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        idle_inputs();
        pixel_rst_n = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'hABCD_0040;
        mem_readdatavalid = 1'b1; mem_readdata = $urandom;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL reset_outputs: got=%h required=0", all_outs);
        end
        #2 pixel_rst_n = 1'b1;
        cyc_begin(); rd_req = 1'b0; wr_req = 1'b0; mem_readdatavalid = 1'b0;
        cyc_sample();
        checks++;
        if (mem_read !== 1'b1 || rd_gnt !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'hABCD_0040) begin
            failures++;
            $display("FAIL first_grant: read=%0b gnt=%0b write=%0b addr=%h required 1 1 0 abcd0040",
                     mem_read, rd_gnt, mem_write, mem_address);
        end
        cyc_begin(); d = $urandom; mem_readdatavalid = 1'b1; mem_readdata = d;
        cyc_sample();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== d) begin
            failures++; $display("FAIL first_beat: valid=%0b data=%h required 1 %h", rd_valid, rd_data, d);
        end
        #1 pixel_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL reset_in_burst: got=%h required=0", all_outs);
        end
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        mem_readdatavalid = 1'b0;
        #2 pixel_rst_n = 1'b1;
    endtask

    task automatic test_read_only();
        logic          v;
        logic [DW-1:0] d;
        int            beats, nread, guard;
        idle_inputs();
        rd_addr = 32'h1000;
        cyc_begin(); rd_req = 1'b1;
        cyc_sample();
        checks++;
        if (mem_read !== 1'b0 || rd_gnt !== 1'b0) begin
            failures++; $display("FAIL rd_idle: read=%0b gnt=%0b required 0 0", mem_read, rd_gnt);
        end
        cyc_begin(); rd_req = 1'b0; rd_addr = $urandom;
        cyc_sample();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h1000 || mem_burstcount !== BCW'(BURST) || rd_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rd_cmd: read=%0b addr=%h bc=%0d gnt=%0b required 1 00001000 %0d 1",
                     mem_read, mem_address, mem_burstcount, rd_gnt, BURST);
        end
        nread = 1; beats = 0;
        for (guard = 0; guard < 200 && beats < BURST; guard++) begin
            cyc_begin(); v = ($urandom_range(0, 2) != 0); d = $urandom;
            mem_readdatavalid = v; mem_readdata = d;
            cyc_sample();
            if (mem_read) nread++;
            checks++;
            if (rd_valid !== v || rd_done !== (v && beats == BURST - 1)) begin
                failures++;
                $display("FAIL rd_beat%0d: valid=%0b done=%0b required %0b %0b",
                         beats, rd_valid, rd_done, v, v && beats == BURST - 1);
            end
            if (v) begin
                checks++;
                if (rd_data !== d) begin
                    failures++; $display("FAIL rd_data%0d: got=%h required=%h", beats, rd_data, d);
                end
                beats++;
            end
        end
        checks++;
        if (beats != BURST || nread != 1) begin
            failures++; $display("FAIL rd_burst: beats=%0d read_cycles=%0d required %0d 1", beats, nread, BURST);
        end
        cyc_begin(); mem_readdatavalid = 1'b0;
        cyc_sample();
        checks++;
        if (mem_read !== 1'b0 || rd_valid !== 1'b0 || rd_done !== 1'b0) begin
            failures++; $display("FAIL rd_after: read=%0b valid=%0b done=%0b required 0 0 0", mem_read, rd_valid, rd_done);
        end
    endtask

    task automatic test_write_stall();
        logic exp_ack;
        idle_inputs();
        wr_addr = 32'h20; wr_data = 32'hA5A5_A5A5;
        cyc_begin(); wr_req = 1'b1; mem_waitrequest = 1'b1;
        cyc_sample();
        for (int k = 0; k < 4; k++) begin
            cyc_begin(); wr_req = 1'b0; wr_addr = $urandom; wr_data = $urandom;
            mem_waitrequest = (k < 3);
            cyc_sample();
            exp_ack = (k == 3);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h20 ||
                mem_writedata !== 32'hA5A5_A5A5 || mem_burstcount !== BCW'(1) || wr_ack !== exp_ack) begin
                failures++;
                $display("FAIL wr_stall%0d: write=%0b addr=%h data=%h bc=%0d ack=%0b required 1 20 a5a5a5a5 1 %0b",
                         k, mem_write, mem_address, mem_writedata, mem_burstcount, wr_ack, exp_ack);
            end
        end
        cyc_begin(); idle_inputs();
        cyc_sample();
        checks++;
        if (mem_write !== 1'b0 || wr_ack !== 1'b0) begin
            failures++; $display("FAIL wr_after: write=%0b ack=%0b required 0 0", mem_write, wr_ack);
        end
    endtask

    // Both requesters held: every (STARVE+1)th grant goes to the writer.
    task automatic test_contention();
        string         got, exp;
        int            pending, beat, guard, after_done;
        logic          v, last_rd, last_wr;
        logic [DW-1:0] d, prev_wd;
        logic [AW-1:0] prev_ra, prev_wa;
        exp = "";
        for (int g = 0; g < 10; g++) exp = {exp, ((g % (STARVE + 1)) == STARVE) ? "W" : "R"};
        idle_inputs();
        got = ""; pending = 0; beat = 0; after_done = 0; last_rd = 1'b0; last_wr = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom;
        for (guard = 0; guard < 3000 && got.len() < 10; guard++) begin
            cyc_begin();
            prev_ra = rd_addr; prev_wa = wr_addr; prev_wd = wr_data;
            rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom;
            mem_waitrequest = ($urandom_range(0, 2) == 0);
            v = (pending > 0) && ($urandom_range(0, 3) != 0);
            d = $urandom;
            mem_readdatavalid = v; mem_readdata = d;
            cyc_sample();
            if (mem_read && !last_rd) begin
                checks++;
                if (mem_address !== prev_ra || mem_burstcount !== BCW'(BURST)) begin
                    failures++; $display("FAIL ct_rd_cmd: addr=%h bc=%0d required %h %0d", mem_address, mem_burstcount, prev_ra, BURST);
                end
            end
            if (mem_write && !last_wr) begin
                checks++;
                if (mem_address !== prev_wa || mem_writedata !== prev_wd || mem_burstcount !== BCW'(1)) begin
                    failures++;
                    $display("FAIL ct_wr_cmd: addr=%h data=%h bc=%0d required %h %h 1",
                             mem_address, mem_writedata, mem_burstcount, prev_wa, prev_wd);
                end
            end
            if (after_done == 1) begin
                checks++;
                if (mem_read || mem_write) begin
                    failures++; $display("FAIL ct_turnaround_idle: read=%0b write=%0b required 0 0", mem_read, mem_write);
                end
                after_done = 2;
            end else if (after_done == 2) begin
                checks++;
                if (!(mem_read || mem_write)) begin
                    failures++; $display("FAIL ct_turnaround_cmd: read=%0b write=%0b required a command", mem_read, mem_write);
                end
                after_done = 0;
            end
            checks++;
            if (rd_valid !== v || rd_done !== (v && beat == BURST - 1)) begin
                failures++;
                $display("FAIL ct_beat: valid=%0b done=%0b required %0b %0b", rd_valid, rd_done, v, v && beat == BURST - 1);
            end
            if (v) begin
                checks++;
                if (rd_data !== d) begin
                    failures++; $display("FAIL ct_data: got=%h required=%h", rd_data, d);
                end
                pending--; beat++;
                if (pending == 0) after_done = 1;
            end
            if (rd_gnt) begin got = {got, "R"}; pending = BURST; beat = 0; end
            if (wr_ack) begin got = {got, "W"}; after_done = 1; end
            last_rd = mem_read; last_wr = mem_write;
        end
        idle_inputs();
        checks++;
        if (got != exp) begin
            failures++; $display("FAIL ct_order: got=%s required=%s", got, exp);
        end
        repeat (3) cyc_begin();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        rd_addr = $urandom;
        cyc_begin(); rd_req = 1'b1; wr_req = 1'b1;
        cyc_sample();
        cyc_begin(); rd_req = 1'b0;
        cyc_sample();
        checks++;
        if (rd_gnt !== 1'b1) begin
            failures++; $display("FAIL rm_gnt: got=%0b required=1", rd_gnt);
        end
        cyc_begin(); wr_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc_begin();
            mem_readdatavalid = 1'b1; mem_readdata = $urandom;
            cyc_sample();
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++; $display("FAIL rm_beat7: valid=%0b required=1", rd_valid);
        end
        cyc_begin(); mem_readdata = $urandom;
        #1 pixel_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL rm_reset_outputs: got=%h required=0", all_outs);
        end
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        #2 pixel_rst_n = 1'b1;
        for (int i = 7; i < BURST; i++) begin
            cyc_begin(); mem_readdatavalid = 1'b1; mem_readdata = $urandom;
            cyc_sample();
            checks++;
            if (rd_valid !== 1'b0 || rd_done !== 1'b0 || mem_read !== 1'b0) begin
                failures++;
                $display("FAIL rm_late_beat%0d: valid=%0b done=%0b read=%0b required 0 0 0", i, rd_valid, rd_done, mem_read);
            end
        end
        cyc_begin(); mem_readdatavalid = 1'b0; wr_req = 1'b1; wr_addr = $urandom; mem_waitrequest = 1'b1;
        cyc_sample();
        cyc_begin(); wr_req = 1'b0;
        cyc_sample();
        checks++;
        if (mem_write !== 1'b1) begin
            failures++; $display("FAIL rm_wr_cmd: write=%0b required=1", mem_write);
        end
        #1 pixel_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL rm_reset_write: got=%h required=0", all_outs);
        end
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        #2 pixel_rst_n = 1'b1;
        mem_waitrequest = 1'b0;
        cyc_begin();
        cyc_sample();
        checks++;
        if (mem_write !== 1'b0 || wr_ack !== 1'b0) begin
            failures++; $display("FAIL rm_wr_after: write=%0b ack=%0b required 0 0", mem_write, wr_ack);
        end
    endtask

    task automatic test_stray();
        logic [DW-1:0] d;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            cyc_begin(); mem_readdatavalid = 1'b1; mem_readdata = $urandom;
            cyc_sample();
            checks++;
            if (rd_valid !== 1'b0 || rd_done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                failures++;
                $display("FAIL stray_idle%0d: valid=%0b done=%0b read=%0b write=%0b required 0 0 0 0",
                         i, rd_valid, rd_done, mem_read, mem_write);
            end
        end
        cyc_begin(); mem_readdatavalid = 1'b0; rd_req = 1'b1; rd_addr = $urandom; mem_waitrequest = 1'b1;
        cyc_sample();
        for (int i = 0; i < 3; i++) begin
            cyc_begin(); rd_req = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = $urandom;
            cyc_sample();
            checks++;
            if (mem_read !== 1'b1 || rd_gnt !== 1'b0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL stray_cmd%0d: read=%0b gnt=%0b valid=%0b required 1 0 0", i, mem_read, rd_gnt, rd_valid);
            end
        end
        cyc_begin(); mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
        cyc_sample();
        checks++;
        if (rd_gnt !== 1'b1) begin
            failures++; $display("FAIL stray_gnt: got=%0b required=1", rd_gnt);
        end
        for (int i = 0; i < BURST; i++) begin
            cyc_begin(); d = $urandom; mem_readdatavalid = 1'b1; mem_readdata = d;
            cyc_sample();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== d || rd_done !== (i == BURST - 1)) begin
                failures++;
                $display("FAIL stray_burst%0d: valid=%0b data=%h done=%0b required 1 %h %0b",
                         i, rd_valid, rd_data, rd_done, d, i == BURST - 1);
            end
        end
        cyc_begin(); mem_readdata = $urandom;
        cyc_sample();
        checks++;
        if (rd_valid !== 1'b0 || rd_done !== 1'b0) begin
            failures++; $display("FAIL stray_after: valid=%0b done=%0b required 0 0", rd_valid, rd_done);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read_only();
        test_write_stall();
        test_contention();
        test_reset_mid_burst();
        test_contention();
        test_stray();
        repeat (2) cyc_begin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
